// File: rtl/cu_pkg.sv
// Shared definitions for the accumulator-processor control unit:
// state encoding, opcode values, A-mux select codes and widths.
package cu_pkg;

    localparam int unsigned N_W  = 8;   // data / IR width
    localparam int unsigned A_W  = 5;   // address / PC width
    localparam int unsigned ST_W = 4;   // state code width

    typedef enum logic [ST_W-1:0] {
        ST_START  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD   = 4'd3,
        ST_STORE  = 4'd4,
        ST_ADD    = 4'd5,
        ST_SUB    = 4'd6,
        ST_INPUT  = 4'd7,
        ST_INREL  = 4'd8,
        ST_JZ     = 4'd9,
        ST_JPOS   = 4'd10,
        ST_HALT   = 4'd11,
        ST_STEPW  = 4'd12
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_INPUT = 3'd4;
    localparam logic [2:0] OP_JZ    = 3'd5;
    localparam logic [2:0] OP_JPOS  = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    localparam logic [1:0] ASEL_SUM  = 2'd0;
    localparam logic [1:0] ASEL_IN   = 2'd1;
    localparam logic [1:0] ASEL_BUS  = 2'd2;
    localparam logic [1:0] ASEL_ZERO = 2'd3;

    // Execute state that follows DECODE for a given opcode.
    function automatic state_t op_to_state(input logic [2:0] op);
        state_t s;
        case (op)
            OP_LOAD:  s = ST_LOAD;
            OP_STORE: s = ST_STORE;
            OP_ADD:   s = ST_ADD;
            OP_SUB:   s = ST_SUB;
            OP_INPUT: s = ST_INPUT;
            OP_JZ:    s = ST_JZ;
            OP_JPOS:  s = ST_JPOS;
            default:  s = ST_HALT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: AW-bit register, synchronous active-high reset,
// increment and load; load wins over increment.
// Ports: clk, reset, inc, load, din[AW-1:0] (jump target), pc[AW-1:0].
module program_counter #(
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          load,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] pc
);

    logic [AW-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else if (load) begin
            pc_q <= din;
        end else if (inc) begin
            pc_q <= pc_q + AW'(1);  // wraps at 2**AW
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/control_sequencer.sv
// Control-unit FSM for the 8-bit accumulator processor. Sequences
// fetch/decode/execute, owns the PC and RAM addressing, and drives the
// A-register datapath controls.
// Ports: clk, reset (sync, active-high), ir, aeq0, apos, enter, step;
//        ir_load, mem_addr, mem_wr, asel, load_a, clear_a, sub, pc, halt,
//        state (debug code).
// Optional: define CU_STEP_EN to insert a single-step wait state (STEPW)
// after every instruction, released by a rising edge on step.
module control_sequencer
    import cu_pkg::*;
#(
    parameter int unsigned n  = 8,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [n-1:0]  ir,
    input  logic          aeq0,
    input  logic          apos,
    input  logic          enter,
    input  logic          step,
    output logic          ir_load,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [1:0]    asel,
    output logic          load_a,
    output logic          clear_a,
    output logic          sub,
    output logic [AW-1:0] pc,
    output logic          halt,
    output logic [3:0]    state
);

    state_t        cur_st;
    state_t        nxt_st;
    logic          pc_inc;
    logic          pc_load;
    logic [AW-1:0] ir_addr;
    logic [2:0]    ir_op;

    assign ir_addr = ir[AW-1:0];
    assign ir_op   = ir[n-1 -: 3];

`ifdef CU_STEP_EN
    localparam state_t DONE_ST = ST_STEPW;
    logic step_q;

    // Previous step level for rising-edge detection in STEPW.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end
`else
    localparam state_t DONE_ST = ST_FETCH;
    logic unused_step;
    assign unused_step = step;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_st <= ST_START;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // Next state and Moore-decoded controls (load_a in INPUT follows enter).
    always_comb begin
        nxt_st   = cur_st;
        ir_load  = 1'b0;
        mem_wr   = 1'b0;
        load_a   = 1'b0;
        clear_a  = 1'b0;
        sub      = 1'b0;
        asel     = ASEL_SUM;
        halt     = 1'b0;
        mem_addr = pc;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        case (cur_st)
            ST_START: begin
                clear_a = 1'b1;
                asel    = ASEL_ZERO;
                load_a  = 1'b1;
                nxt_st  = ST_FETCH;
            end
            ST_FETCH: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                nxt_st  = ST_DECODE;
            end
            ST_DECODE: begin
                // Present the operand address a cycle early for RAM latency.
                mem_addr = ir_addr;
                nxt_st   = op_to_state(ir_op);
            end
            ST_LOAD: begin
                mem_addr = ir_addr;
                asel     = ASEL_BUS;
                load_a   = 1'b1;
                nxt_st   = DONE_ST;
            end
            ST_STORE: begin
                mem_addr = ir_addr;
                mem_wr   = 1'b1;
                nxt_st   = DONE_ST;
            end
            ST_ADD: begin
                mem_addr = ir_addr;
                load_a   = 1'b1;
                nxt_st   = DONE_ST;
            end
            ST_SUB: begin
                mem_addr = ir_addr;
                sub      = 1'b1;
                load_a   = 1'b1;
                nxt_st   = DONE_ST;
            end
            ST_INPUT: begin
                asel   = ASEL_IN;
                load_a = enter;
                if (enter) begin
                    nxt_st = ST_INREL;
                end
            end
            ST_INREL: begin
                // Hold off until enter drops so one press gives one load.
                if (!enter) begin
                    nxt_st = DONE_ST;
                end
            end
            ST_JZ: begin
                pc_load = aeq0;
                nxt_st  = DONE_ST;
            end
            ST_JPOS: begin
                pc_load = apos;
                nxt_st  = DONE_ST;
            end
            ST_HALT: begin
                halt = 1'b1;
            end
`ifdef CU_STEP_EN
            ST_STEPW: begin
                if (step && !step_q) begin
                    nxt_st = ST_FETCH;
                end
            end
`endif
            default: begin
                nxt_st = ST_START;
            end
        endcase
    end

    program_counter #(
        .AW (AW)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_inc),
        .load  (pc_load),
        .din   (ir_addr),
        .pc    (pc)
    );

    assign state = cur_st;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a small RAM/IR/accumulator
// environment. Compile with or without CU_STEP_EN.
module tb_control_sequencer;
    import cu_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] ir_q;
    logic       aeq0;
    logic       apos;
    logic       enter;
    logic       step;
    logic       ir_load;
    logic [4:0] mem_addr;
    logic       mem_wr;
    logic [1:0] asel;
    logic       load_a;
    logic       clear_a;
    logic       sub;
    logic [4:0] pc;
    logic       halt;
    logic [3:0] dut_state;

    logic [7:0] mem      [32];
    logic [7:0] init_mem [32];
    logic [7:0] a_q;
    logic [7:0] in_val;
    logic       do_init;
    logic       step_auto;
    int         n_in_loads;
    int         n_wr;
    int         n_cmp;
    int         n_err;
    int         cyc;

    control_sequencer #(.n(8), .AW(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .ir       (ir_q),
        .aeq0     (aeq0),
        .apos     (apos),
        .enter    (enter),
        .step     (step),
        .ir_load  (ir_load),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .asel     (asel),
        .load_a   (load_a),
        .clear_a  (clear_a),
        .sub      (sub),
        .pc       (pc),
        .halt     (halt),
        .state    (dut_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign aeq0 = (a_q == 8'h00);
    assign apos = ~a_q[7];

    // Environment: RAM, IR and accumulator reacting to the DUT controls.
    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
            a_q        <= 8'h00;
            ir_q       <= 8'h00;
            n_in_loads <= 0;
            n_wr       <= 0;
        end else begin
            if (ir_load) ir_q <= mem[mem_addr];
            if (mem_wr) begin
                mem[mem_addr] <= a_q;
                n_wr          <= n_wr + 1;
            end
            if (clear_a) begin
                a_q <= 8'h00;
            end else if (load_a) begin
                case (asel)
                    2'd0: a_q <= sub ? a_q - mem[mem_addr] : a_q + mem[mem_addr];
                    2'd1: begin
                        a_q        <= in_val;
                        n_in_loads <= n_in_loads + 1;
                    end
                    2'd2: a_q <= mem[mem_addr];
                    default: a_q <= 8'h00;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        if (step_auto) step = ~step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_prog();
        for (int i = 0; i < 32; i++) init_mem[i] = 8'hE0;
    endtask

    // Reset with program preload; leaves the DUT observed in START.
    task automatic do_reset();
        do_init = 1'b1;
        reset   = 1'b1;
        tick();
        do_init = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic run_until_halt(input int budget, output int cycles);
        cycles = 0;
        while (!halt && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("halt_reached", 32'(halt), 32'd1);
    endtask

    task automatic run_until_state(input state_t st, input int budget);
        int c;
        c = 0;
        while (dut_state != st && c < budget) begin
            tick();
            c++;
        end
        chk("state_reached", 32'(dut_state), 32'(st));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        enter     = 1'b0;
        step      = 1'b0;
        step_auto = 1'b1;
        in_val    = 8'h5A;
        do_init   = 1'b0;

        // LOAD 5 / ADD 6 / STORE 7 / HALT
        clr_prog();
        init_mem[0] = 8'h05; init_mem[1] = 8'h46;
        init_mem[2] = 8'h27; init_mem[3] = 8'hE0;
        init_mem[5] = 8'h03; init_mem[6] = 8'h04; init_mem[7] = 8'h00;
        do_reset();
        chk("rst_state", 32'(dut_state), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_clear_a", 32'(clear_a), 32'd1);
        chk("rst_asel", 32'(asel), 32'd3);
        chk("rst_load_a", 32'(load_a), 32'd1);
        chk("rst_halt", 32'(halt), 32'd0);
        run_until_halt(200, cyc);
`ifndef CU_STEP_EN
        chk("prog_cycles", 32'(cyc), 32'd12);
`endif
        chk("prog_m7", 32'(mem[7]), 32'd7);
        chk("prog_pc", 32'(pc), 32'd4);
        chk("prog_state", 32'(dut_state), 32'd11);
        chk("prog_wr_count", 32'(n_wr), 32'd1);
        repeat (5) tick();
        chk("halt_stays", 32'(halt), 32'd1);
        chk("halt_pc_stays", 32'(pc), 32'd4);
        chk("halt_no_ir_load", 32'(ir_load), 32'd0);

        // Reset during ADD execute
        do_reset();
        run_until_state(ST_ADD, 50);
        chk("add_mem_addr", 32'(mem_addr), 32'd6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_state", 32'(dut_state), 32'd0);
        chk("midrst_clear_a", 32'(clear_a), 32'd1);
        chk("midrst_asel", 32'(asel), 32'd3);
        chk("midrst_load_a", 32'(load_a), 32'd1);
        chk("midrst_pc", 32'(pc), 32'd0);
        tick();
        chk("midrst_fetch", 32'(dut_state), 32'd1);
        chk("midrst_fetch_addr", 32'(mem_addr), 32'd0);
        chk("midrst_ir_load", 32'(ir_load), 32'd1);

        // SUB to zero, JZ 20 taken
        clr_prog();
        init_mem[0] = 8'h05; init_mem[1] = 8'h65; init_mem[2] = 8'hB4;
        init_mem[5] = 8'h03;
        do_reset();
        run_until_halt(200, cyc);
        chk("sub_a_zero", 32'(a_q), 32'd0);
        chk("jz_taken_pc", 32'(pc), 32'd21);

        // A=1, JZ 20 not taken
        clr_prog();
        init_mem[0] = 8'h05; init_mem[1] = 8'h66; init_mem[2] = 8'hB4;
        init_mem[5] = 8'h03; init_mem[6] = 8'h02;
        do_reset();
        run_until_halt(200, cyc);
        chk("sub_a_one", 32'(a_q), 32'd1);
        chk("jz_nottaken_pc", 32'(pc), 32'd4);

        // A=0x80, JPOS 20 not taken
        clr_prog();
        init_mem[0] = 8'h05; init_mem[1] = 8'hD4; init_mem[5] = 8'h80;
        do_reset();
        run_until_halt(200, cyc);
        chk("jpos_neg_pc", 32'(pc), 32'd3);

        // INPUT handshake, then STORE 9
        clr_prog();
        init_mem[0] = 8'h80; init_mem[1] = 8'h29;
        do_reset();
        run_until_state(ST_INPUT, 50);
        step_auto = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("in_wait_load_a", 32'(load_a), 32'd0);
            chk("in_wait_asel", 32'(asel), 32'd1);
            tick();
        end
        chk("in_still_wait", 32'(dut_state), 32'd7);
        enter = 1'b1;
        #1;
        chk("in_load_a", 32'(load_a), 32'd1);
        chk("in_asel", 32'(asel), 32'd1);
        tick();
        chk("inrel_state", 32'(dut_state), 32'd8);
        chk("inrel_load_a", 32'(load_a), 32'd0);
        tick();
        tick();
        chk("inrel_hold", 32'(dut_state), 32'd8);
        enter = 1'b0;
        tick();
`ifdef CU_STEP_EN
        chk("in_done", 32'(dut_state), 32'd12);
`else
        chk("in_done", 32'(dut_state), 32'd1);
`endif
        step_auto = 1'b1;
        run_until_halt(200, cyc);
        chk("in_m9", 32'(mem[9]), 32'h5A);
        chk("in_load_count", 32'(n_in_loads), 32'd1);

        // JPOS 31 taken with A=0, FETCH at 31 wraps pc to 0
        clr_prog();
        init_mem[0] = 8'hDF;
        do_reset();
        run_until_state(ST_JPOS, 50);
        tick();
        chk("jpos_taken_pc", 32'(pc), 32'd31);
        run_until_halt(200, cyc);
        chk("pc_wrap", 32'(pc), 32'd0);

`ifdef CU_STEP_EN
        // Step held high: only the first instruction runs
        clr_prog();
        init_mem[0] = 8'h05; init_mem[1] = 8'h46; init_mem[5] = 8'h03;
        step_auto = 1'b0;
        step      = 1'b1;
        do_reset();
        repeat (20) tick();
        chk("step_hold_state", 32'(dut_state), 32'd12);
        chk("step_hold_pc", 32'(pc), 32'd1);
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        chk("step_edge_fetch", 32'(dut_state), 32'd1);
        repeat (3) tick();
        chk("step_one_more", 32'(dut_state), 32'd12);
        chk("step_one_more_pc", 32'(pc), 32'd2);
        repeat (10) tick();
        chk("step_hold_again_pc", 32'(pc), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
